// File: rtl/seven_seg_scan_decoder_if.sv
// Frame delivery channel of the scanned seven-segment decoder.
// The master holds out_* stable while out_valid=1 and out_ready=0; a transfer happens on a clock edge with out_valid & out_ready.
interface seven_seg_scan_decoder_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_digits;
    logic [3:0]  out_dp;
    logic [3:0]  out_err;

    modport master (
        output out_valid,
        output out_digits,
        output out_dp,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digits,
        input  out_dp,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers four hex digits and decimal points from a scanned 4-digit seven-segment bus.
// Each complete frame is delivered on a valid/ready channel.
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 65536,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       seven_seg,
    input  logic [3:0]                       digit_en,
    seven_seg_scan_decoder_if.master         frame,
    output logic                             overrun,
    output logic                             stale
);

    localparam int unsigned TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    CNT_MAX  = 8'(SETTLE);
    localparam logic [7:0]    CAP_AT   = 8'(SETTLE - 2);

    logic [11:0]   sync1;
    logic [11:0]   sync2;
    logic [11:0]   prev;
    logic [7:0]    cnt;
    logic [7:0]    seg;
    logic [3:0]    dig;
    logic          same;
    logic          onehot;
    logic          capture;
    logic [1:0]    idx;
    logic [4:0]    dec;
    logic [3:0]    slot_val [4];
    logic [3:0]    slot_dp;
    logic [3:0]    slot_err;
    logic [3:0]    mask;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic          complete;

    // Returns {err, value}; anything outside the sixteen hex glyphs is an error showing 0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        seg         = sync2[7:0] ^ {8{SEG_ACTIVE_LOW}};
        dig         = sync2[11:8] ^ {4{DIG_ACTIVE_LOW}};
        same        = (sync2 == prev);
        onehot      = (dig != 4'h0) && ((dig & (dig - 4'd1)) == 4'h0);
        // cnt lands on SETTLE-1 on the capture edge; saturation blocks a second capture in one dwell.
        capture     = same && (cnt == CAP_AT) && onehot;
        dec         = decode(seg[6:0]);
        timeout_hit = (tcnt == T_LAST);
        complete    = (mask == 4'hF);
        idx         = 2'd0;
        case (dig)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {digit_en, seven_seg};
            sync2 <= sync1;
            prev  <= sync2;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask             <= '0;
            tcnt             <= '0;
            stale            <= 1'b0;
            overrun          <= 1'b0;
            slot_dp          <= '0;
            slot_err         <= '0;
            for (int i = 0; i < 4; i++) slot_val[i] <= '0;
            frame.out_valid  <= 1'b0;
            frame.out_digits <= '0;
            frame.out_dp     <= '0;
            frame.out_err    <= '0;
        end else begin
            overrun <= 1'b0;

            if (capture) begin
                slot_val[idx] <= dec[3:0];
                slot_dp[idx]  <= seg[7];
                slot_err[idx] <= dec[4];
                tcnt          <= '0;
                stale         <= 1'b0;
            end else if (timeout_hit) begin
                stale <= 1'b1;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            if (complete) begin
                mask <= capture ? dig : 4'h0;
            end else if (capture) begin
                mask <= mask | dig;
            end else if (timeout_hit) begin
                mask <= 4'h0;
            end

            // A completed frame replaces the held one only if the held one leaves this cycle.
            if (complete) begin
                if (!frame.out_valid || frame.out_ready) begin
                    frame.out_valid  <= 1'b1;
                    frame.out_digits <= {slot_val[3], slot_val[2], slot_val[1], slot_val[0]};
                    frame.out_dp     <= slot_dp;
                    frame.out_err    <= slot_err;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame.out_valid && frame.out_ready) begin
                frame.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: scanned-bus stimulus, frame scoreboard, and an inverted-polarity instance.
module tb_seven_seg_scan_decoder;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seven_seg   = 8'h00;
  logic [3:0] digit_en    = 4'h0;
  logic [7:0] seven_seg_n = 8'hFF;
  logic [3:0] digit_en_n  = 4'hF;
  logic       overrun, stale, overrun_n, stale_n;

  seven_seg_scan_decoder_if ifc ();
  seven_seg_scan_decoder_if ifc_n ();

  seven_seg_scan_decoder #(
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seven_seg(seven_seg), .digit_en(digit_en),
    .frame(ifc), .overrun(overrun), .stale(stale)
  );

  seven_seg_scan_decoder #(
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .seven_seg(seven_seg_n), .digit_en(digit_en_n),
    .frame(ifc_n), .overrun(overrun_n), .stale(stale_n)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  int ov_cnt = 0;
  int t_stale0, t_valid, first_stale;
  logic [23:0] exp_q[$];
  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: frame {err, dp, digits} from the four raw patterns by glyph-table lookup.
  function automatic logic [23:0] ref_frame(input logic [31:0] pats);
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  er;
    logic [7:0]  p;
    d  = '0;
    dp = '0;
    er = 4'hF;
    for (int i = 0; i < 4; i++) begin
      p     = pats[8*i +: 8];
      dp[i] = p[7];
      for (int v = 0; v < 16; v++) begin
        if (pat_tab[v] == p[6:0]) begin
          d[4*i +: 4] = 4'(v);
          er[i]       = 1'b0;
        end
      end
    end
    return {er, dp, d};
  endfunction

  // driver tasks
  task automatic show(input bit sel, input logic [7:0] seg, input logic [3:0] dig, input int dwell);
    @(posedge clk);
    #1;
    if (sel) begin
      seven_seg_n = ~seg;
      digit_en_n  = ~dig;
    end else begin
      seven_seg = seg;
      digit_en  = dig;
    end
    t_stale0 = 0;
    t_valid  = 0;
    for (int k = 1; k < dwell; k++) begin
      @(posedge clk);
      #1;
      if (t_stale0 == 0 && !stale) t_stale0 = k;
      if (t_valid == 0 && ifc.out_valid) t_valid = k;
    end
  endtask

  task automatic scan(input bit sel, input logic [31:0] pats, input bit push, input int dwell);
    if (push) exp_q.push_back(ref_frame(pats));
    for (int i = 0; i < 4; i++) begin
      show(sel, pats[8*i +: 8], 4'(1 << i), (dwell == 0) ? int'($urandom_range(12, SETTLE)) : dwell);
      if (i == 0) first_stale = t_stale0;
    end
  endtask

  // monitor: pops on transfer, checks the held frame every cycle it is presented
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ov_cnt++;
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h want none", {ifc.out_err, ifc.out_dp, ifc.out_digits});
        end else begin
          check("frame", {8'h00, ifc.out_err, ifc.out_dp, ifc.out_digits}, {8'h00, exp_q[0]});
          if (ifc.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pats;
    logic [7:0]  p;
    logic [23:0] e;
    ifc.out_ready   = 1'b1;
    ifc_n.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_main", {ifc.out_valid, ifc.out_digits, ifc.out_dp, ifc.out_err, overrun, stale}, 32'h0);
    check("reset_inv", {ifc_n.out_valid, ifc_n.out_digits, ifc_n.out_dp, ifc_n.out_err, overrun_n, stale_n}, 32'h0);
    rst_n = 1'b1;

    // idle past the timeout, then the first frame measures capture and completion latency
    repeat (TIMEOUT + 6) @(posedge clk);
    #1;
    check("stale_idle", 32'(stale), 32'd1);
    check("valid_idle", 32'(ifc.out_valid), 32'd0);
    scan(1'b0, {8'h66, 8'h4F, 8'h5B, 8'h06}, 1'b1, 20);
    check("capture_latency", 32'(first_stale), 32'(SETTLE + 2));
    check("frame_latency", 32'(t_valid), 32'(SETTLE + 3));
    check("stale_after_frame", 32'(stale), 32'd0);

    // blank and dp+0 slots
    scan(1'b0, {8'h3F, 8'h00, 8'hBF, 8'h3F}, 1'b1, 20);

    // glitches: short dwells, multi-hot and zero enables
    for (int i = 0; i < 4; i++) show(1'b0, 8'h7F, 4'(1 << i), SETTLE - 1);
    show(1'b0, 8'h06, 4'b0011, 20);
    show(1'b0, 8'h06, 4'b0000, 20);
    check("glitch_no_valid", 32'(ifc.out_valid), 32'd0);

    // randomized clean frames with random dwell down to exactly SETTLE
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7, 0) == 0) p = 8'($urandom);
        else p = {1'($urandom), pat_tab[$urandom_range(15, 0)]};
        pats[8*i +: 8] = p;
      end
      scan(1'b0, pats, 1'b1, 0);
    end
    repeat (8) @(posedge clk);
    #1;
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // backpressure: second frame is dropped with a one-cycle overrun
    ifc.out_ready = 1'b0;
    ov_cnt = 0;
    scan(1'b0, {8'h77, 8'h6D, 8'h39, 8'h4F}, 1'b1, 20);
    scan(1'b0, {8'h06, 8'h06, 8'h06, 8'h06}, 1'b0, 20);
    repeat (5) @(posedge clk);
    #1;
    check("overrun_pulses", 32'(ov_cnt), 32'd1);
    check("held_digits", 32'(ifc.out_digits), 32'h0000A5C3);
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("valid_after_transfer", 32'(ifc.out_valid), 32'd0);
    check("overrun_drained", 32'(exp_q.size()), 32'd0);

    // timeout discards a partial frame
    show(1'b0, 8'h7D, 4'b0001, 20);
    show(1'b0, 8'h07, 4'b0010, 20);
    show(1'b0, 8'h7F, 4'b0100, 20);
    check("stale_partial", 32'(stale), 32'd0);
    show(1'b0, 8'h00, 4'b0000, TIMEOUT + 10);
    check("stale_timeout", 32'(stale), 32'd1);
    exp_q.push_back(ref_frame({8'h5E, 8'h7C, 8'h77, 8'h6F}));
    show(1'b0, 8'h5E, 4'b1000, 20);
    check("stale_cleared", 32'(stale), 32'd0);
    show(1'b0, 8'h6F, 4'b0001, 20);
    show(1'b0, 8'h77, 4'b0010, 20);
    show(1'b0, 8'h7C, 4'b0100, 20);
    repeat (4) @(posedge clk);
    #1;
    check("timeout_drained", 32'(exp_q.size()), 32'd0);

    // inverted-polarity instance
    pats = {8'h7C, 8'h79, 8'h79, 8'h71};
    e = ref_frame(pats);
    scan(1'b1, pats, 1'b0, 20);
    repeat (3) @(posedge clk);
    #1;
    check("inv_valid", 32'(ifc_n.out_valid), 32'd1);
    check("inv_digits", 32'(ifc_n.out_digits), 32'h0000BEEF);
    check("inv_frame", {8'h00, ifc_n.out_err, ifc_n.out_dp, ifc_n.out_digits}, {8'h00, e});

    // reset mid-scan with a frame held on the main instance
    ifc.out_ready = 1'b0;
    scan(1'b0, {8'h5B, 8'h66, 8'h7D, 8'h7F}, 1'b1, 20);
    show(1'b0, 8'h06, 4'b0001, 20);
    show(1'b1, 8'h71, 4'b0001, 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_main", {ifc.out_valid, ifc.out_digits, ifc.out_dp, ifc.out_err, overrun, stale}, 32'h0);
    check("midreset_inv", {ifc_n.out_valid, ifc_n.out_digits, ifc_n.out_dp, ifc_n.out_err, overrun_n, stale_n}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_valid", {31'd0, ifc.out_valid | ifc_n.out_valid}, 32'd0);
    check("overrun_total", 32'(ov_cnt), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
